udm_cpu_bus_arbiter: RTL

- Two-master, one-slave arbiter sharing a single data-memory port.
- Master 0 is the UART debug master (UDM); master 1 is the CPU data bus.
- Sits inside the memsplit subsystem, between both masters and the data RAM / GPIO bus.
- Selects the master for each transaction, holds the selection until the transaction is accepted, and routes read responses back to their issuer through an in-order ID queue.

---
 rtl/udm_cpu_bus_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/udm_cpu_bus_arbiter.sv
// Two-master arbiter (m0 = UART debug master, m1 = CPU data bus) onto one data-memory port.
// Holds a grant until the slave accepts it and routes in-order read responses back via an ID queue.
module udm_cpu_bus_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int RR_ENABLE       = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_i,

  input  logic                      m0_req_i,
  output logic                      m0_ack_o,
  input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
  input  logic                      m0_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_be_i,
  input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
  output logic                      m0_resp_o,
  output logic [DATA_WIDTH-1:0]     m0_rdata_o,

  input  logic                      m1_req_i,
  output logic                      m1_ack_o,
  input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
  input  logic                      m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_be_i,
  input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
  output logic                      m1_resp_o,
  output logic [DATA_WIDTH-1:0]     m1_rdata_o,

  output logic                      s_req_o,
  input  logic                      s_ack_i,
  output logic [ADDR_WIDTH-1:0]     s_addr_o,
  output logic                      s_we_o,
  output logic [DATA_WIDTH/8-1:0]   s_be_o,
  output logic [DATA_WIDTH-1:0]     s_wdata_o,
  input  logic                      s_resp_i,
  input  logic [DATA_WIDTH-1:0]     s_rdata_i,

  output logic                      err_o
);

  // state      | meaning
  // ST_OPEN    | no handshake in flight, arbitrate every cycle
  // ST_LOCKED  | request shown to slave but not yet accepted, grant frozen on lock_id

  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(MAX_OUTSTANDING);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  lock_id_q, lock_id_d;
  logic                  last_id_q, last_id_d;

  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  err_q;

  logic                  sel;
  logic                  sel_req;
  logic                  sel_we;
  logic                  stall;
  logic                  xfer;
  logic                  push;
  logic                  pop;
  logic                  head_id;

  always_comb begin
    sel     = 1'b0;
    sel_req = 1'b0;
    if (state_q == ST_LOCKED) begin
      sel     = lock_id_q;
      sel_req = lock_id_q ? m1_req_i : m0_req_i;
    end else if (m0_req_i && m1_req_i) begin
      sel     = (RR_ENABLE != 0) ? ~last_id_q : 1'b0;
      sel_req = 1'b1;
    end else if (m1_req_i) begin
      sel     = 1'b1;
      sel_req = 1'b1;
    end else if (m0_req_i) begin
      sel     = 1'b0;
      sel_req = 1'b1;
    end
  end

  assign sel_we    = sel ? m1_we_i    : m0_we_i;
  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel_we;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  // A full queue blocks reads even when a response frees a slot this cycle.
  assign stall   = sel_req && !sel_we && (count_q == CNT_FULL);
  assign s_req_o = sel_req && !stall;
  assign xfer    = s_req_o && s_ack_i;

  assign m0_ack_o = xfer && !sel;
  assign m1_ack_o = xfer &&  sel;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    last_id_d = last_id_q;
    if (xfer) begin
      state_d   = ST_OPEN;
      last_id_d = sel;
    end else if (s_req_o) begin
      state_d   = ST_LOCKED;
      lock_id_d = sel;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= ST_OPEN;
      lock_id_q <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      last_id_q <= last_id_d;
    end
  end

  assign push    = xfer && !sel_we;
  assign pop     = s_resp_i && (count_q != '0);
  assign head_id = id_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= wr_ptr_q + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
      // A response with nothing outstanding is dropped and flagged until reset.
      if (s_resp_i && (count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign m0_resp_o  = pop && !head_id;
  assign m1_resp_o  = pop &&  head_id;
  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;
  assign err_o      = err_q;

endmodule
